// File: rtl/chan_io_dispatch.sv
// Purpose : single-outstanding host-to-channel I/O dispatcher; decodes the
//           channel index from host_addr, broadcasts the slave access to the
//           selected channel I/O block and returns the read result/status.
// Latency : write -> host_done 2 cycles after acceptance; read -> host_done
//           1 cycle after the selected channel's ack is sampled (earliest
//           2 cycles after acceptance); bad request -> host_done next cycle.
// Backpressure: host_ready is high only in IDLE; host_req is ignored (never
//           queued) while busy.
//
// Ports:
//   io_clk, io_reset           clock, synchronous active-high reset
//   host_req/host_ready        request strobe / dispatcher idle
//   host_rd_en/host_wr_en      request direction (exactly one must be set)
//   host_addr, host_wr_data    [31:20] channel index, [19:0] slave address
//   host_done/host_err         one-cycle completion pulse / failure flag
//   host_rd_data, err_cnt      read result, saturating failure counter
//   io_sel, io_sync            one-hot channel select, one-cycle start strobe
//   io_addr/io_rd_en/io_wr_en/io_wr_data   broadcast to all channels
//   chan_rd_data, chan_rd_ack  per-channel read data and acknowledge
//
// Optional feature: define CHAN_IO_TIMEOUT_EN to enable the read-ack
// watchdog (TIMEOUT cycles in WAIT_ACK without an ack fails the read).

module chan_io_dispatch #(
  parameter int NCHAN   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic                  io_clk,
  input  logic                  io_reset,
  input  logic                  host_req,
  output logic                  host_ready,
  input  logic                  host_rd_en,
  input  logic                  host_wr_en,
  input  logic [31:0]           host_addr,
  input  logic [31:0]           host_wr_data,
  output logic                  host_done,
  output logic                  host_err,
  output logic [31:0]           host_rd_data,
  output logic [7:0]            err_cnt,
  output logic [NCHAN-1:0]      io_sel,
  output logic                  io_sync,
  output logic [19:0]           io_addr,
  output logic                  io_rd_en,
  output logic                  io_wr_en,
  output logic [31:0]           io_wr_data,
  input  logic [32*NCHAN-1:0]   chan_rd_data,
  input  logic [NCHAN-1:0]      chan_rd_ack
);

  // Elaboration-time parameter range checks.
  if (NCHAN < 1 || NCHAN > 16) begin : g_bad_nchan
    $error("chan_io_dispatch: NCHAN out of range 1..16");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("chan_io_dispatch: TIMEOUT out of range 2..255");
  end

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ISSUE    = 2'd1;
  localparam logic [1:0] S_WAIT_ACK = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam logic [11:0] NCHAN_W  = 12'(NCHAN);
  localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

  // State and registered outputs
  logic [1:0]       state_q,      state_d;
  logic [NCHAN-1:0] io_sel_q,     io_sel_d;
  logic             io_sync_q,    io_sync_d;
  logic [19:0]      io_addr_q,    io_addr_d;
  logic             io_rd_en_q,   io_rd_en_d;
  logic             io_wr_en_q,   io_wr_en_d;
  logic [31:0]      io_wr_data_q, io_wr_data_d;
  logic             host_done_q,  host_done_d;
  logic             host_err_q,   host_err_d;
  logic [31:0]      rd_data_q,    rd_data_d;
  logic [7:0]       err_cnt_q,    err_cnt_d;
`ifdef CHAN_IO_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  logic [7:0]       wd_cnt_q,     wd_cnt_d;
`endif

  // Request decode (combinational on the host inputs, used only in IDLE)
  logic [11:0]      req_chan;
  logic             req_bad;
  logic [NCHAN-1:0] sel_dec;

  assign req_chan = host_addr[31:20];
  // A request must name an existing channel and exactly one direction.
  assign req_bad  = (req_chan >= NCHAN_W) || (host_rd_en == host_wr_en);

  always_comb begin
    sel_dec = '0;
    for (int k = 0; k < NCHAN; k++) begin
      sel_dec[k] = (req_chan == 12'(k));
    end
  end

  // Ack/data from the selected channel only; acks of other channels are
  // masked out by the registered one-hot select.
  logic        ack_hit;
  logic [31:0] sel_rd_data;

  assign ack_hit = |(chan_rd_ack & io_sel_q);

  always_comb begin
    sel_rd_data = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (io_sel_q[k]) begin
        sel_rd_data = sel_rd_data | chan_rd_data[32*k +: 32];
      end
    end
  end

  // Saturating increment of the failure counter
  logic [7:0] err_cnt_inc;
  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? 8'hFF : (err_cnt_q + 8'd1);

  always_comb begin
    state_d      = state_q;
    io_sel_d     = io_sel_q;
    io_sync_d    = 1'b0;
    io_addr_d    = io_addr_q;
    io_rd_en_d   = io_rd_en_q;
    io_wr_en_d   = io_wr_en_q;
    io_wr_data_d = io_wr_data_q;
    host_done_d  = 1'b0;
    host_err_d   = 1'b0;
    rd_data_d    = rd_data_q;
    err_cnt_d    = err_cnt_q;
`ifdef CHAN_IO_TIMEOUT_EN
    wd_cnt_d     = wd_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (host_req) begin
          if (req_bad) begin
            // Fail locally: channel interface is left untouched.
            state_d     = S_DONE;
            host_done_d = 1'b1;
            host_err_d  = 1'b1;
            rd_data_d   = BAD_DATA;
            err_cnt_d   = err_cnt_inc;
          end else begin
            state_d      = S_ISSUE;
            io_sel_d     = sel_dec;
            io_sync_d    = 1'b1;
            io_addr_d    = host_addr[19:0];
            io_rd_en_d   = host_rd_en;
            io_wr_en_d   = host_wr_en;
            io_wr_data_d = host_wr_data;
          end
        end
      end

      S_ISSUE: begin
        if (io_rd_en_q) begin
          if (ack_hit) begin
            // Ack coincident with io_sync is a valid completion.
            state_d     = S_DONE;
            host_done_d = 1'b1;
            rd_data_d   = sel_rd_data;
          end else begin
            state_d = S_WAIT_ACK;
`ifdef CHAN_IO_TIMEOUT_EN
            wd_cnt_d = 8'd0;
`endif
          end
        end else begin
          state_d     = S_DONE;
          host_done_d = 1'b1;
        end
      end

      S_WAIT_ACK: begin
        if (ack_hit) begin
          state_d     = S_DONE;
          host_done_d = 1'b1;
          rd_data_d   = sel_rd_data;
        end
`ifdef CHAN_IO_TIMEOUT_EN
        // Counter holds the number of WAIT_ACK cycles already spent; the
        // read fails after TIMEOUT of them without an ack.
        else if ((wd_cnt_q + 8'd1) == TIMEOUT_C) begin
          state_d     = S_DONE;
          host_done_d = 1'b1;
          host_err_d  = 1'b1;
          rd_data_d   = BAD_DATA;
          err_cnt_d   = err_cnt_inc;
        end else begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
`endif
      end

      S_DONE: begin
        // Channel interface held through the done cycle, released after.
        state_d    = S_IDLE;
        io_sel_d   = '0;
        io_rd_en_d = 1'b0;
        io_wr_en_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge io_clk) begin
    if (io_reset) begin
      state_q      <= S_IDLE;
      io_sel_q     <= '0;
      io_sync_q    <= 1'b0;
      io_addr_q    <= '0;
      io_rd_en_q   <= 1'b0;
      io_wr_en_q   <= 1'b0;
      io_wr_data_q <= '0;
      host_done_q  <= 1'b0;
      host_err_q   <= 1'b0;
      rd_data_q    <= '0;
      err_cnt_q    <= '0;
`ifdef CHAN_IO_TIMEOUT_EN
      wd_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      io_sel_q     <= io_sel_d;
      io_sync_q    <= io_sync_d;
      io_addr_q    <= io_addr_d;
      io_rd_en_q   <= io_rd_en_d;
      io_wr_en_q   <= io_wr_en_d;
      io_wr_data_q <= io_wr_data_d;
      host_done_q  <= host_done_d;
      host_err_q   <= host_err_d;
      rd_data_q    <= rd_data_d;
      err_cnt_q    <= err_cnt_d;
`ifdef CHAN_IO_TIMEOUT_EN
      wd_cnt_q     <= wd_cnt_d;
`endif
    end
  end

  assign host_ready   = (state_q == S_IDLE);
  assign host_done    = host_done_q;
  assign host_err     = host_err_q;
  assign host_rd_data = rd_data_q;
  assign err_cnt      = err_cnt_q;
  assign io_sel       = io_sel_q;
  assign io_sync      = io_sync_q;
  assign io_addr      = io_addr_q;
  assign io_rd_en     = io_rd_en_q;
  assign io_wr_en     = io_wr_en_q;
  assign io_wr_data   = io_wr_data_q;

endmodule

// File: tb/tb_chan_io_dispatch.sv
// Directed bench for chan_io_dispatch: expected completions are queued when a
// request is driven and checked by a monitor on every host_done pulse;
// cycle-exact interface behaviour is checked inline in the stimulus.
module tb_chan_io_dispatch;
  localparam int NCHAN   = 5;
  localparam int TIMEOUT = 16;

  logic                io_clk = 1'b0;
  logic                io_reset;
  logic                host_req, host_ready, host_rd_en, host_wr_en;
  logic [31:0]         host_addr, host_wr_data;
  logic                host_done, host_err;
  logic [31:0]         host_rd_data;
  logic [7:0]          err_cnt;
  logic [NCHAN-1:0]    io_sel;
  logic                io_sync;
  logic [19:0]         io_addr;
  logic                io_rd_en, io_wr_en;
  logic [31:0]         io_wr_data;
  logic [32*NCHAN-1:0] chan_rd_data;
  logic [NCHAN-1:0]    chan_rd_ack;

  always #5 io_clk = ~io_clk;

  chan_io_dispatch #(.NCHAN(NCHAN), .TIMEOUT(TIMEOUT)) dut (
    .io_clk(io_clk), .io_reset(io_reset),
    .host_req(host_req), .host_ready(host_ready),
    .host_rd_en(host_rd_en), .host_wr_en(host_wr_en),
    .host_addr(host_addr), .host_wr_data(host_wr_data),
    .host_done(host_done), .host_err(host_err),
    .host_rd_data(host_rd_data), .err_cnt(err_cnt),
    .io_sel(io_sel), .io_sync(io_sync), .io_addr(io_addr),
    .io_rd_en(io_rd_en), .io_wr_en(io_wr_en), .io_wr_data(io_wr_data),
    .chan_rd_data(chan_rd_data), .chan_rd_ack(chan_rd_ack)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   n_push   = 0;

  logic [31:0] ch_dat [NCHAN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic e, input logic [31:0] d);
    exp_t x;
    x.err = e;
    x.dat = d;
    sb.push_back(x);
    n_push++;
  endtask

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  // Drive one request for one cycle; returns in the cycle after acceptance.
  task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] dat);
    chk("ready_before_req", 32'(host_ready), 32'd1);
    host_req     = 1'b1;
    host_rd_en   = rd;
    host_wr_en   = wr;
    host_addr    = addr;
    host_wr_data = dat;
    tick();
    host_req     = 1'b0;
    host_rd_en   = 1'b0;
    host_wr_en   = 1'b0;
  endtask

  // Completion monitor
  always @(negedge io_clk) begin
    exp_t e;
    if (host_done === 1'b1) begin
      n_done++;
      chk("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("done_err", 32'(host_err), 32'(e.err));
        chk("done_rd_data", host_rd_data, e.dat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_err;

    ch_dat[0] = 32'hC0DE_0000;
    ch_dat[1] = 32'h1234_5678;
    ch_dat[2] = 32'hC0DE_0002;
    ch_dat[3] = 32'hC0DE_0003;
    ch_dat[4] = 32'hC0DE_0004;
    for (int k = 0; k < NCHAN; k++) chan_rd_data[32*k +: 32] = ch_dat[k];

    io_reset = 1'b1; host_req = 1'b0; host_rd_en = 1'b0; host_wr_en = 1'b0;
    host_addr = '0; host_wr_data = '0; chan_rd_ack = '0;
    repeat (2) tick();

    // Reset state
    chk("rst_ready", 32'(host_ready), 32'd1);
    chk("rst_done", 32'(host_done), 32'd0);
    chk("rst_err", 32'(host_err), 32'd0);
    chk("rst_rd_data", host_rd_data, 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_io_sel", 32'(io_sel), 32'd0);
    chk("rst_io_sync", 32'(io_sync), 32'd0);
    chk("rst_io_rd_en", 32'(io_rd_en), 32'd0);
    chk("rst_io_wr_en", 32'(io_wr_en), 32'd0);
    chk("rst_io_addr", 32'(io_addr), 32'd0);
    chk("rst_io_wr_data", io_wr_data, 32'd0);
    io_reset = 1'b0;
    tick();
    exp_err = 8'd0;

    // Write to channel 2, slave address 1, data 5
    push(1'b0, 32'd0);
    req(1'b0, 1'b1, 32'h0020_0001, 32'd5);
    chk("wr_io_sync", 32'(io_sync), 32'd1);
    chk("wr_io_sel", 32'(io_sel), 32'b00100);
    chk("wr_io_addr", 32'(io_addr), 32'd1);
    chk("wr_io_wr_en", 32'(io_wr_en), 32'd1);
    chk("wr_io_rd_en", 32'(io_rd_en), 32'd0);
    chk("wr_io_wr_data", io_wr_data, 32'd5);
    chk("wr_busy", 32'(host_ready), 32'd0);
    chk("wr_no_early_done", 32'(host_done), 32'd0);
    tick();
    chk("wr_done", 32'(host_done), 32'd1);
    chk("wr_err", 32'(host_err), 32'd0);
    chk("wr_sync_one_cycle", 32'(io_sync), 32'd0);
    chk("wr_sel_held", 32'(io_sel), 32'b00100);
    tick();
    chk("wr_done_pulse", 32'(host_done), 32'd0);
    chk("wr_sel_cleared", 32'(io_sel), 32'd0);
    chk("wr_wr_en_cleared", 32'(io_wr_en), 32'd0);

    // Read channel 1, ack one cycle after io_sync
    push(1'b0, 32'h1234_5678);
    req(1'b1, 1'b0, 32'h0010_0002, 32'd0);
    chk("rd_io_sync", 32'(io_sync), 32'd1);
    chk("rd_io_sel", 32'(io_sel), 32'b00010);
    chk("rd_io_addr", 32'(io_addr), 32'd2);
    chk("rd_io_rd_en", 32'(io_rd_en), 32'd1);
    tick();
    chk("rd_wait_sync", 32'(io_sync), 32'd0);
    chk("rd_wait_done", 32'(host_done), 32'd0);
    chan_rd_ack = 5'b00010;
    tick();
    chan_rd_ack = '0;
    chk("rd_done", 32'(host_done), 32'd1);
    chk("rd_data", host_rd_data, 32'h1234_5678);
    tick();
    chk("rd_rd_en_cleared", 32'(io_rd_en), 32'd0);

    // Bad channel index (== NCHAN)
    push(1'b1, 32'hDEAD_BEEF);
    exp_err = exp_err + 8'd1;
    req(1'b1, 1'b0, 32'h0050_0000, 32'd0);
    chk("badch_io_sync", 32'(io_sync), 32'd0);
    chk("badch_io_sel", 32'(io_sel), 32'd0);
    chk("badch_done", 32'(host_done), 32'd1);
    chk("badch_err", 32'(host_err), 32'd1);
    chk("badch_err_cnt", 32'(err_cnt), 32'(exp_err));
    tick();
    chk("badch_io_sync_after", 32'(io_sync), 32'd0);

    // Both directions set
    push(1'b1, 32'hDEAD_BEEF);
    exp_err = exp_err + 8'd1;
    req(1'b1, 1'b1, 32'h0000_0003, 32'd0);
    chk("both_io_sync", 32'(io_sync), 32'd0);
    chk("both_err_cnt", 32'(err_cnt), 32'(exp_err));
    tick();

    // Neither direction set
    push(1'b1, 32'hDEAD_BEEF);
    exp_err = exp_err + 8'd1;
    req(1'b0, 1'b0, 32'h0000_0003, 32'd0);
    chk("none_io_sync", 32'(io_sync), 32'd0);
    chk("none_err_cnt", 32'(err_cnt), 32'(exp_err));
    tick();

    // Write to highest channel keeps previous read data
    push(1'b0, 32'hDEAD_BEEF);
    req(1'b0, 1'b1, 32'h0040_0010, 32'hA5A5_5A5A);
    chk("wr4_io_sel", 32'(io_sel), 32'b10000);
    chk("wr4_io_wr_data", io_wr_data, 32'hA5A5_5A5A);
    tick();
    chk("wr4_rd_data_kept", host_rd_data, 32'hDEAD_BEEF);
    tick();

    // Read channel 2 with spurious channel-0 ack and an ignored busy request
    push(1'b0, ch_dat[2]);
    req(1'b1, 1'b0, 32'h0020_0007, 32'd0);
    chan_rd_ack = 5'b00001;
    host_req = 1'b1; host_wr_en = 1'b1; host_addr = 32'h0030_0000;
    chk("spur_io_sel", 32'(io_sel), 32'b00100);
    tick();
    chk("spur_ignored_1", 32'(host_done), 32'd0);
    chk("busy_req_sel", 32'(io_sel), 32'b00100);
    chk("busy_req_sync", 32'(io_sync), 32'd0);
    tick();
    chk("spur_ignored_2", 32'(host_done), 32'd0);
    host_req = 1'b0; host_wr_en = 1'b0;
    chan_rd_ack = 5'b00101;
    tick();
    chan_rd_ack = '0;
    chk("spur_done", 32'(host_done), 32'd1);
    chk("spur_rd_data", host_rd_data, ch_dat[2]);
    tick();
    chk("busy_req_not_queued_ready", 32'(host_ready), 32'd1);
    tick();
    chk("busy_req_not_queued_sync", 32'(io_sync), 32'd0);

    // Ack in the same cycle as io_sync
    push(1'b0, ch_dat[3]);
    req(1'b1, 1'b0, 32'h0030_0004, 32'd0);
    chan_rd_ack = 5'b01000;
    chk("same_io_sync", 32'(io_sync), 32'd1);
    tick();
    chan_rd_ack = '0;
    chk("same_done", 32'(host_done), 32'd1);
    chk("same_rd_data", host_rd_data, ch_dat[3]);
    tick();

    // Reset during WAIT_ACK, then a late ack (no completion expected)
    req(1'b1, 1'b0, 32'h0040_0000, 32'd0);
    tick();
    tick();
    chk("rstw_waiting", 32'(host_ready), 32'd0);
    io_reset = 1'b1;
    tick();
    io_reset = 1'b0;
    chan_rd_ack = 5'b10000;
    chk("rstw_ready", 32'(host_ready), 32'd1);
    chk("rstw_err_cnt", 32'(err_cnt), 32'd0);
    chk("rstw_io_sel", 32'(io_sel), 32'd0);
    chk("rstw_io_rd_en", 32'(io_rd_en), 32'd0);
    tick();
    chk("rstw_no_done_1", 32'(host_done), 32'd0);
    chk("rstw_ready_after", 32'(host_ready), 32'd1);
    tick();
    chk("rstw_no_done_2", 32'(host_done), 32'd0);
    chan_rd_ack = '0;
    exp_err = 8'd0;

`ifdef CHAN_IO_TIMEOUT_EN
    // No ack: read fails after TIMEOUT cycles in WAIT_ACK
    push(1'b1, 32'hDEAD_BEEF);
    exp_err = exp_err + 8'd1;
    req(1'b1, 1'b0, 32'h0000_0000, 32'd0);
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      chk("to_waiting", 32'(host_done), 32'd0);
    end
    tick();
    chk("to_done", 32'(host_done), 32'd1);
    chk("to_err", 32'(host_err), 32'd1);
    chk("to_rd_data", host_rd_data, 32'hDEAD_BEEF);
    chk("to_err_cnt", 32'(err_cnt), 32'(exp_err));
    tick();
`else
    // Without the watchdog a read waits indefinitely for its ack
    push(1'b0, ch_dat[0]);
    req(1'b1, 1'b0, 32'h0000_0000, 32'd0);
    for (int i = 0; i < 3 * TIMEOUT; i++) begin
      tick();
      chk("nto_waiting", 32'(host_done), 32'd0);
    end
    chan_rd_ack = 5'b00001;
    tick();
    chan_rd_ack = '0;
    chk("nto_done", 32'(host_done), 32'd1);
    chk("nto_rd_data", host_rd_data, ch_dat[0]);
    chk("nto_err_cnt", 32'(err_cnt), 32'(exp_err));
    tick();
`endif

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin
      push(1'b1, 32'hDEAD_BEEF);
      exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
      req(1'b1, 1'b1, 32'h0000_0000, 32'd0);
      tick();
    end
    chk("sat_err_cnt", 32'(err_cnt), 32'(exp_err));

    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'(n_push));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/chan_io_dispatch.md
CHAN_IO_DISPATCH -- requirements
Module: chan_io_dispatch

Interface
REQ-001 SHALL have parameter NCHAN, default 5: number of channel I/O blocks served, 1..16.
REQ-002 SHALL have parameter TIMEOUT, default 16: read-ack watchdog limit in io_clk cycles, 2..255.
REQ-003 SHALL have port io_clk  in  1  single clock for all logic.
REQ-004 SHALL have port io_reset  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port host_req  in  1  request strobe, taken only when host_ready=1.
REQ-006 SHALL have port host_ready  out  1  dispatcher idle, can accept a request.
REQ-007 SHALL have port host_rd_en  in  1  request is a read.
REQ-008 SHALL have port host_wr_en  in  1  request is a write.
REQ-009 SHALL have port host_addr  in  32  [31:20] channel index, [19:0] slave address.
REQ-010 SHALL have port host_wr_data  in  32  write data.
REQ-011 SHALL have port host_done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port host_err  out  1  qualifies host_done; the transaction failed.
REQ-013 SHALL have port host_rd_data  out  32  read result, valid with host_done.
REQ-014 SHALL have port err_cnt  out  8  saturating count of failed transactions.
REQ-015 SHALL have port io_sel  out  NCHAN  one-hot channel select.
REQ-016 SHALL have port io_sync  out  1  one-cycle operation start.
REQ-017 SHALL have ports io_addr, io_rd_en, io_wr_en, io_wr_data  out  20/1/1/32  broadcast to all channels.
REQ-018 SHALL have port chan_rd_data  in  32*NCHAN  per-channel read data; channel k at [32k+31:32k].
REQ-019 SHALL have port chan_rd_ack  in  NCHAN  per-channel read acknowledge.

Function
REQ-020 SHALL implement the FSM IDLE -> ISSUE -> (WAIT_ACK for reads) -> DONE -> IDLE; host_ready=1 only in IDLE.
REQ-021 SHALL accept a request on a cycle with host_req=1 and host_ready=1, and register host_addr, host_wr_data and host_rd_en/host_wr_en at that edge.
REQ-022 SHALL treat the request as bad when host_addr[31:20]>=NCHAN, or when host_rd_en and host_wr_en are equal: go directly to DONE, no io_sel or io_sync asserted.
REQ-023 SHALL, in ISSUE (the cycle after acceptance), drive io_sync=1 for exactly one cycle with io_sel, io_addr, io_rd_en, io_wr_en and io_wr_data valid.
REQ-024 SHALL hold io_sel, io_addr, io_rd_en, io_wr_en and io_wr_data stable from ISSUE until host_done, then clear io_sel, io_rd_en and io_wr_en to 0.
REQ-025 SHALL, on a write, go ISSUE -> DONE: host_done pulses 2 cycles after acceptance with host_err=0.
REQ-026 SHALL, on a read, wait in WAIT_ACK for chan_rd_ack of the selected channel; chan_rd_ack bits of other channels are ignored.
REQ-027 SHALL capture the selected chan_rd_data slice into host_rd_data on the cycle the ack is sampled high, and pulse host_done on the following cycle.
REQ-028 SHALL handle an ack arriving in the same cycle as io_sync as valid.
REQ-029 SHALL keep host_rd_data unchanged after a write.
REQ-030 SHALL set host_rd_data=32'hDEAD_BEEF on a bad request.
REQ-031 SHALL, for every failed transaction, assert host_err together with host_done and increment err_cnt, which saturates at 8'hFF.
REQ-032 SHALL ignore host_req while host_ready=0; the request is not queued.

Reset
REQ-033 SHALL, when io_reset=1 at a clock edge, enter IDLE and set host_ready=1, host_done=0, host_err=0, host_rd_data=0, err_cnt=0, io_sel=0, io_sync=0, io_rd_en=0, io_wr_en=0, io_addr=0 and io_wr_data=0.
REQ-034 SHALL, on reset mid-transaction, abort with no host_done pulse; a late chan_rd_ack after reset is ignored.

Configuration
REQ-035 SHALL, with macro CHAN_IO_TIMEOUT_EN defined, run an 8-bit counter in WAIT_ACK that is cleared on entry.
REQ-036 SHALL, with CHAN_IO_TIMEOUT_EN defined, go to DONE when the counter reaches TIMEOUT with no ack, with host_err=1 and host_rd_data=32'hDEAD_BEEF.
REQ-037 SHALL, without CHAN_IO_TIMEOUT_EN, omit the counter; WAIT_ACK is left only on ack or reset, and err_cnt counts only bad requests.

Verification
REQ-038 SHALL cover: write, host_addr=32'h0020_0001, data 5 -> io_sel=5'b00100, io_addr=1, io_sync one cycle; host_done 2 cycles after acceptance, host_err=0.
REQ-039 SHALL cover: read, host_addr=32'h0010_0002; channel 1 acks 1 cycle after io_sync with 32'h1234_5678 -> host_rd_data=32'h1234_5678, host_err=0.
REQ-040 SHALL cover: host_addr[31:20]=5 with NCHAN=5 -> io_sync never asserted, host_done with host_err=1, err_cnt=1.
REQ-041 SHALL cover: CHAN_IO_TIMEOUT_EN defined, TIMEOUT=16, no ack -> host_done with host_err=1 and host_rd_data=32'hDEAD_BEEF after 16 WAIT_ACK cycles.
REQ-042 SHALL cover: read of channel 2 with a spurious ack on channel 0 -> ignored; the channel-2 ack completes the read.
REQ-043 SHALL cover: io_reset pulsed during WAIT_ACK, then a channel ack -> no host_done; host_ready=1 on the cycle after reset is released.
